pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 5, meaning total cycles a multiply occupies EX; legal range 3..16.
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ld_stall  input  1  load-use hazard detected in ID.
REQ-005 SHALL have port mul_start  input  1  multiply in EX, first cycle.
REQ-006 SHALL have port branch_taken  input  1  taken branch/jump resolved in EX.
REQ-007 SHALL have port ext_hold  input  1  memory not ready; freeze whole pipe.
REQ-008 SHALL have ports if_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  output  1 each  hold the named stage/register.
REQ-009 SHALL have ports if_id_flush, id_ex_flush  output  1 each  load bubble (all-zero) into the named register.
REQ-010 SHALL have port mul_busy  output  1  multiply occupying EX.
REQ-011 SHALL have port state  output  2  FSM state: 00 RUN, 01 MUL_WAIT, 10 FLUSH.
REQ-012 SHALL have port stall_count  output  32  cycles with if_stall=1 since reset.

Function
REQ-013 SHALL implement FSM {RUN, MUL_WAIT, FLUSH} plus a 4-bit down-counter mul_cnt.
REQ-014 Input priority SHALL be: ext_hold > mul_start > branch_taken > ld_stall.
REQ-015 ext_hold=1 (any state): all five stall outputs=1, both flushes=0, FSM and mul_cnt frozen.
REQ-016 RUN, mul_start=1: if_stall, if_id_stall, id_ex_stall=1, ex_mem_flush not driven; next state MUL_WAIT, mul_cnt<=MUL_LATENCY-3.
REQ-017 MUL_WAIT: if_stall, if_id_stall, id_ex_stall=1, ex_mem_stall=mem_wb_stall=0; mul_cnt==0 -> RUN, else mul_cnt decrements.
REQ-018 Multiply SHALL therefore hold EX for exactly MUL_LATENCY cycles (stall asserted MUL_LATENCY-1 consecutive cycles).
REQ-019 mul_busy SHALL be 1 in MUL_WAIT and in RUN when mul_start=1 and ext_hold=0.
REQ-020 RUN, branch_taken=1 (no mul_start): if_id_flush=1, id_ex_flush=1, no stalls; next state FLUSH.
REQ-021 FLUSH: if_id_flush=1 for one cycle, no stalls; next state RUN unconditionally.
REQ-022 RUN, ld_stall=1 only: if_stall=1, if_id_stall=1, id_ex_flush=1; state remains RUN.
REQ-023 mul_start and branch_taken same cycle: mul_start wins, branch_taken ignored.
REQ-024 branch_taken, ld_stall, mul_start in MUL_WAIT or FLUSH SHALL be ignored.
REQ-025 ld_stall with mul_start: mul behaviour only (ID/EX held, not flushed).
REQ-026 All stall/flush/mul_busy outputs SHALL be combinational from state, mul_cnt and current inputs; no added latency.
REQ-027 stall_count SHALL increment by 1 on each edge where if_stall=1 and reset=0; wraps 0xFFFFFFFF -> 0.
REQ-028 With no inputs asserted in RUN, all stall/flush outputs SHALL be 0.

Reset
REQ-029 While reset=1, all stall, flush and mul_busy outputs SHALL be 0 regardless of inputs.
REQ-030 On edge with reset=1: state<=RUN, mul_cnt<=0, stall_count<=0, including mid-multiply or mid-FLUSH.

Verification
REQ-031 MUL_LATENCY=5, mul_start pulse at cycle N -> if_stall=1 cycles N..N+3, 0 at N+4; state 01 at N+1..N+3; stall_count=4.
REQ-032 branch_taken at cycle N in RUN -> both flushes=1 at N, if_id_flush only at N+1 (state 10), all 0 at N+2.
REQ-033 ld_stall for 1 cycle -> if_stall=if_id_stall=id_ex_flush=1 that cycle, state stays 00, stall_count=1.
REQ-034 ext_hold=1 for 3 cycles at MUL_WAIT with mul_cnt=1 -> all five stalls=1, mul_cnt stays 1, multiply ends 3 cycles later than without hold.
REQ-035 mul_start+branch_taken+ld_stall same cycle -> mul sequence only, no flush, state 01 next.
REQ-036 reset asserted at second MUL_WAIT cycle -> outputs 0 immediately, state 00 and stall_count 0 after edge; stall_count preload near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard inputs and stage stall/flush controls for pipe_ctrl
//   hazard inputs : ld_stall, mul_start, branch_taken, ext_hold
//   stall outputs : if_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall
//   flush outputs : if_id_flush, id_ex_flush
//   status        : mul_busy, state[1:0], stall_count[31:0]
interface pipe_ctrl_if;
   logic        ld_stall;
   logic        mul_start;
   logic        branch_taken;
   logic        ext_hold;
   logic        if_stall;
   logic        if_id_stall;
   logic        id_ex_stall;
   logic        ex_mem_stall;
   logic        mem_wb_stall;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        mul_busy;
   logic [1:0]  state;
   logic [31:0] stall_count;
   modport master (
      output ld_stall, mul_start, branch_taken, ext_hold,
      input  if_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
      input  if_id_flush, id_ex_flush, mul_busy, state, stall_count
   );
   modport slave (
      input  ld_stall, mul_start, branch_taken, ext_hold,
      output if_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
      output if_id_flush, id_ex_flush, mul_busy, state, stall_count
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline hazard controller (multiply hold, branch flush, load-use stall, external freeze)
//   clock, reset : rising-edge clock, synchronous active-high reset
//   p (slave)    : hazard inputs in, per-stage stall/flush, mul_busy, state, stall_count out
module pipe_ctrl #(
   parameter int MUL_LATENCY = 5
) (
   input logic      clock,
   input logic      reset,
   pipe_ctrl_if.slave p
);
   typedef enum logic [1:0] {RUN = 2'b00, MUL_WAIT = 2'b01, FLUSH = 2'b10} state_t;
   state_t      st, st_nx;
   logic [3:0]  mul_cnt, cnt_nx;
   logic [31:0] stall_cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         st        <= RUN;
         mul_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         st        <= st_nx;
         mul_cnt   <= cnt_nx;
         stall_cnt <= stall_cnt + 32'(p.if_stall);
      end
   end
   // The start cycle plus MUL_WAIT cycles for counts L-3..0 gives L-1 stalled cycles.
   always_comb begin
      st_nx          = st;
      cnt_nx         = mul_cnt;
      p.if_stall     = 1'b0;
      p.if_id_stall  = 1'b0;
      p.id_ex_stall  = 1'b0;
      p.ex_mem_stall = 1'b0;
      p.mem_wb_stall = 1'b0;
      p.if_id_flush  = 1'b0;
      p.id_ex_flush  = 1'b0;
      if (reset) begin
         st_nx  = RUN;
         cnt_nx = '0;
      end else if (p.ext_hold) begin
         p.if_stall     = 1'b1;
         p.if_id_stall  = 1'b1;
         p.id_ex_stall  = 1'b1;
         p.ex_mem_stall = 1'b1;
         p.mem_wb_stall = 1'b1;
      end else begin
         case (st)
            RUN: begin
               if (p.mul_start) begin
                  p.if_stall    = 1'b1;
                  p.if_id_stall = 1'b1;
                  p.id_ex_stall = 1'b1;
                  st_nx         = MUL_WAIT;
                  cnt_nx        = 4'(MUL_LATENCY - 3);
               end else if (p.branch_taken) begin
                  p.if_id_flush = 1'b1;
                  p.id_ex_flush = 1'b1;
                  st_nx         = FLUSH;
               end else if (p.ld_stall) begin
                  p.if_stall    = 1'b1;
                  p.if_id_stall = 1'b1;
                  p.id_ex_flush = 1'b1;
               end
            end
            MUL_WAIT: begin
               p.if_stall    = 1'b1;
               p.if_id_stall = 1'b1;
               p.id_ex_stall = 1'b1;
               st_nx         = (mul_cnt == 4'd0) ? RUN : MUL_WAIT;
               cnt_nx        = (mul_cnt == 4'd0) ? mul_cnt : mul_cnt - 4'd1;
            end
            FLUSH: begin
               p.if_id_flush = 1'b1;
               st_nx         = RUN;
            end
            default: st_nx = RUN;
         endcase
      end
   end
   // Busy stays high through an external freeze while the multiply still owns EX.
   assign p.mul_busy    = !reset && (st == MUL_WAIT || (st == RUN && p.mul_start && !p.ext_hold));
   assign p.state       = st;
   assign p.stall_count = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl with MUL_LATENCY=5
module tb_pipe_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [7:0] outs;
   pipe_ctrl_if bus ();
   pipe_ctrl #(.MUL_LATENCY(5)) dut (.clock(clock), .reset(reset), .p(bus));
   always #5 clock = ~clock;
   // {if, if_id, id_ex, ex_mem, mem_wb stalls, if_id_flush, id_ex_flush, mul_busy}
   assign outs = {bus.if_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                  bus.mem_wb_stall, bus.if_id_flush, bus.id_ex_flush, bus.mul_busy};
   localparam logic [7:0] O_NONE = 8'b0000_0000;
   localparam logic [7:0] O_MUL  = 8'b1110_0001;
   localparam logic [7:0] O_LD   = 8'b1100_0010;
   localparam logic [7:0] O_BR   = 8'b0000_0110;
   localparam logic [7:0] O_FL   = 8'b0000_0100;
   localparam logic [7:0] O_HOLD = 8'b1111_1000;
   localparam logic [7:0] O_HMUL = 8'b1111_1001;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic h, input logic m, input logic b, input logic l);
      bus.ext_hold     = h;
      bus.mul_start    = m;
      bus.branch_taken = b;
      bus.ld_stall     = l;
      #1;
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   initial begin
      drive(1, 1, 1, 1);
      chk("rst_outs", 32'(outs), 32'(O_NONE));
      tick();
      chk("rst_state", 32'(bus.state), 0);
      chk("rst_cnt", bus.stall_count, 0);
      reset = 1'b0;
      drive(0, 0, 0, 0);
      chk("idle_outs", 32'(outs), 32'(O_NONE));
      tick();
      // multiply: stalls N..N+3, MUL_WAIT N+1..N+3
      drive(0, 1, 0, 0);
      chk("mul_n_outs", 32'(outs), 32'(O_MUL));
      tick();
      drive(0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         chk("mul_wait_state", 32'(bus.state), 1);
         chk("mul_wait_outs", 32'(outs), 32'(O_MUL));
         tick();
      end
      chk("mul_end_state", 32'(bus.state), 0);
      chk("mul_end_outs", 32'(outs), 32'(O_NONE));
      chk("mul_cnt4", bus.stall_count, 4);
      // load-use stall
      drive(0, 0, 0, 1);
      chk("ld_outs", 32'(outs), 32'(O_LD));
      tick();
      drive(0, 0, 0, 0);
      chk("ld_state", 32'(bus.state), 0);
      chk("ld_cnt", bus.stall_count, 5);
      // branch, with hazards ignored during FLUSH
      drive(0, 0, 1, 0);
      chk("br_outs", 32'(outs), 32'(O_BR));
      tick();
      drive(0, 1, 1, 1);
      chk("fl_state", 32'(bus.state), 2);
      chk("fl_outs", 32'(outs), 32'(O_FL));
      tick();
      drive(0, 0, 0, 0);
      chk("fl_end_state", 32'(bus.state), 0);
      chk("fl_end_outs", 32'(outs), 32'(O_NONE));
      chk("br_cnt", bus.stall_count, 5);
      // all three together: multiply wins, others ignored in MUL_WAIT
      drive(0, 1, 1, 1);
      chk("combo_outs", 32'(outs), 32'(O_MUL));
      tick();
      drive(0, 0, 1, 1);
      chk("combo_state", 32'(bus.state), 1);
      chk("combo_wait_outs", 32'(outs), 32'(O_MUL));
      tick();
      drive(0, 0, 0, 0);
      tick();
      tick();
      chk("combo_end_state", 32'(bus.state), 0);
      chk("combo_cnt", bus.stall_count, 9);
      // ext_hold for 3 cycles at MUL_WAIT with mul_cnt=1
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      chk("h_cnt2", 32'(dut.mul_cnt), 2);
      tick();
      chk("h_cnt1", 32'(dut.mul_cnt), 1);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("hold_outs", 32'(outs), 32'(O_HMUL));
         tick();
         chk("hold_mulcnt", 32'(dut.mul_cnt), 1);
         chk("hold_state", 32'(bus.state), 1);
      end
      drive(0, 0, 0, 0);
      chk("post_hold_outs", 32'(outs), 32'(O_MUL));
      tick();
      chk("post_hold_cnt0", 32'(dut.mul_cnt), 0);
      chk("post_hold_state", 32'(bus.state), 1);
      tick();
      chk("hold_end_state", 32'(bus.state), 0);
      chk("hold_end_outs", 32'(outs), 32'(O_NONE));
      chk("hold_stallcnt", bus.stall_count, 16);
      // ext_hold beats mul_start in RUN
      drive(1, 1, 0, 0);
      chk("hold_run_outs", 32'(outs), 32'(O_HOLD));
      tick();
      drive(0, 0, 0, 0);
      chk("hold_run_state", 32'(bus.state), 0);
      chk("hold_run_cnt", bus.stall_count, 17);
      // reset during second MUL_WAIT cycle
      drive(0, 1, 0, 0);
      tick();
      drive(0, 0, 0, 0);
      tick();
      reset = 1'b1;
      drive(0, 0, 1, 1);
      chk("midrst_outs", 32'(outs), 32'(O_NONE));
      tick();
      chk("midrst_state", 32'(bus.state), 0);
      chk("midrst_cnt", bus.stall_count, 0);
      chk("midrst_mulcnt", 32'(dut.mul_cnt), 0);
      reset = 1'b0;
      drive(0, 0, 0, 0);
      chk("midrst_idle", 32'(outs), 32'(O_NONE));
      // stall_count wrap
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      drive(0, 0, 0, 1);
      tick();
      chk("wrap_max", bus.stall_count, 32'hFFFF_FFFF);
      tick();
      drive(0, 0, 0, 0);
      chk("wrap_zero", bus.stall_count, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
